// File: rtl/risc23_pkg.sv
// rtl/risc23_pkg.sv - shared types and constants for the IITB-RISC-23 LM/SM sequencer
package risc23_pkg;

  typedef logic [2:0] reg_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lmsm_state_t;

  localparam int LMSM_ADDR_STEP = 2;

endpackage

// File: rtl/lsb_priority_encoder.sv
// rtl/lsb_priority_encoder.sv - lowest-set-bit index, one-hot and single-bit flag of an 8-bit vector
module lsb_priority_encoder
  import risc23_pkg::*;
(
  input  logic [7:0] bits,
  output reg_addr_t  index,
  output logic [7:0] onehot,
  output logic       only_one
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot   = bits & (~bits + 8'd1);
  assign only_one = (bits != 8'd0) && ((bits & (bits - 8'd1)) == 8'd0);

  always_comb begin
    index = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bits[i]) index = reg_addr_t'(i);
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - expands an LM/SM descriptor into one memory micro-op per mask bit
// Optional abort input enabled by defining LMSM_ABORT_EN.
module lmsm_sequencer
  import risc23_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = LMSM_ADDR_STEP
) (
  input  logic              clk,
  input  logic              rst,
`ifdef LMSM_ABORT_EN
  input  logic              flush,
`endif
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              start_is_load,
  input  logic [7:0]        start_mask,
  input  logic [ADDR_W-1:0] start_base,
  input  logic              stall_in,
  output logic              uop_valid,
  output logic              uop_is_load,
  output reg_addr_t         uop_reg,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_rf_we,
  output logic              uop_last,
  output logic              frontend_stall
);

  lmsm_state_t       state;
  logic [7:0]        mask_r;
  logic [ADDR_W-1:0] addr_r;
  logic              is_load_r;

  reg_addr_t  low_index;
  logic [7:0] low_onehot;
  logic       only_one;
  logic       abort;
  logic       run;

  lsb_priority_encoder u_enc (
    .bits     (mask_r),
    .index    (low_index),
    .onehot   (low_onehot),
    .only_one (only_one)
  );

`ifdef LMSM_ABORT_EN
  assign abort = flush;
`else
  assign abort = 1'b0;
`endif

  assign run = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mask_r    <= '0;
      addr_r    <= '0;
      is_load_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A zero-mask descriptor is consumed here without leaving IDLE.
          if (start_valid && (start_mask != 8'd0)) begin
            mask_r    <= start_mask;
            addr_r    <= start_base;
            is_load_r <= start_is_load;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            mask_r <= '0;
            state  <= IDLE;
          end else if (!stall_in) begin
            mask_r <= mask_r & ~low_onehot;
            addr_r <= addr_r + ADDR_W'(ADDR_STEP);
            if (only_one) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign start_ready    = !run;
  assign frontend_stall = run;
  assign uop_valid      = run;
  assign uop_is_load    = run & is_load_r;
  assign uop_rf_we      = run & is_load_r;
  assign uop_last       = run & only_one;
  assign uop_reg        = run ? low_index : reg_addr_t'(0);
  assign uop_addr       = run ? addr_r : '0;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb/tb_lmsm_sequencer.sv - table-driven scoreboard bench for lmsm_sequencer (LMSM_ABORT_EN adds the flush case)
module tb_lmsm_sequencer;

  typedef struct {
    logic        ld;
    logic [7:0]  mask;
    logic [15:0] base;
    int          stall;
  } vec_t;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] addr;
    logic        ld;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic        start_is_load = 1'b0;
  logic [7:0]  start_mask = 8'd0;
  logic [15:0] start_base = 16'd0;
  logic        stall_in = 1'b0;
  logic        uop_valid, uop_is_load, uop_rf_we, uop_last, frontend_stall;
  logic [2:0]  uop_reg;
  logic [15:0] uop_addr;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t e;
  vec_t vecs[6];

  lmsm_sequencer dut (
    .clk            (clk),
    .rst            (rst),
`ifdef LMSM_ABORT_EN
    .flush          (flush),
`endif
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .start_is_load  (start_is_load),
    .start_mask     (start_mask),
    .start_base     (start_base),
    .stall_in       (stall_in),
    .uop_valid      (uop_valid),
    .uop_is_load    (uop_is_load),
    .uop_reg        (uop_reg),
    .uop_addr       (uop_addr),
    .uop_rf_we      (uop_rf_we),
    .uop_last       (uop_last),
    .frontend_stall (frontend_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_model(input vec_t v);
    logic [15:0] a;
    int left;
    a = v.base;
    left = $countones(v.mask);
    for (int i = 0; i < 8; i++) begin
      if (v.mask[i]) begin
        q.push_back('{r: 3'(i), addr: a, ld: v.ld, last: (left == 1)});
        a = a + 16'd2;
        left--;
      end
    end
  endtask

  // Scoreboard: compare the head entry every presented cycle; pop only on advance.
  always @(negedge clk) begin
    if (!rst && uop_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_uop", 1, 0);
      end else begin
        e = q[0];
        chk("uop_reg", uop_reg, e.r);
        chk("uop_addr", uop_addr, e.addr);
        chk("uop_is_load", uop_is_load, e.ld);
        chk("uop_rf_we", uop_rf_we, e.ld);
        chk("uop_last", uop_last, e.last);
        if (!stall_in && !flush) q.delete(0);
      end
    end
  end

  task automatic accept(input vec_t v);
    @(posedge clk); #1;
    start_valid = 1'b1;
    start_is_load = v.ld;
    start_mask = v.mask;
    start_base = v.base;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drain_timeout"}, (n >= 200), 0);
    chk({name, "_ready_after"}, start_ready, 1);
    chk({name, "_valid_after"}, uop_valid, 0);
    chk({name, "_fstall_after"}, frontend_stall, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    push_model(v);
    accept(v);
    stall_in = (v.stall > 0);
    chk({nm, "_first_valid"}, uop_valid, (v.mask != 0));
    chk({nm, "_fstall"}, frontend_stall, (v.mask != 0));
    chk({nm, "_ready"}, start_ready, (v.mask == 0));
    for (int s = 0; s < v.stall; s++) begin
      @(posedge clk); #1;
      chk({nm, "_held_reg"}, uop_reg, (v.mask == 0) ? 0 : q[0].r);
    end
    stall_in = 1'b0;
    drain(nm);
  endtask

  initial begin
    vecs[0] = '{ld: 1'b1, mask: 8'b1010_0101, base: 16'h0100, stall: 0};
    vecs[1] = '{ld: 1'b0, mask: 8'b0000_0011, base: 16'h0200, stall: 3};
    vecs[2] = '{ld: 1'b1, mask: 8'b0000_0000, base: 16'h0300, stall: 0};
    vecs[3] = '{ld: 1'b1, mask: 8'b1100_0000, base: 16'hFFFE, stall: 0};
    vecs[4] = '{ld: 1'b0, mask: 8'b1000_0000, base: 16'h1234, stall: 1};
    vecs[5] = '{ld: 1'b1, mask: 8'hFF,        base: 16'h0010, stall: 2};

    #1;
    chk("rst_ready", start_ready, 1);
    chk("rst_valid", uop_valid, 0);
    chk("rst_fstall", frontend_stall, 0);
    chk("rst_addr", uop_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // start_valid during RUN must be ignored.
    begin
      vec_t v;
      v = '{ld: 1'b0, mask: 8'b0000_0011, base: 16'h0040, stall: 0};
      push_model(v);
      accept(v);
      start_valid = 1'b1;
      start_mask = 8'hF0;
      start_base = 16'h0500;
      @(posedge clk); #1;
      start_valid = 1'b0;
      drain("ignore_start");
      repeat (3) @(posedge clk);
      #1 chk("ignore_start_idle", uop_valid, 0);
    end

    // Asynchronous reset in the middle of a sequence.
    begin
      vec_t v;
      v = '{ld: 1'b1, mask: 8'hFF, base: 16'h0800, stall: 0};
      push_model(v);
      accept(v);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_valid", uop_valid, 0);
      chk("midrst_ready", start_ready, 1);
      chk("midrst_fstall", frontend_stall, 0);
      chk("midrst_rfwe", uop_rf_we, 0);
      chk("midrst_reg", uop_reg, 0);
      chk("midrst_addr", uop_addr, 0);
      q.delete();
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("midrst_stays_idle", uop_valid, 0);
    end

`ifdef LMSM_ABORT_EN
    begin
      vec_t v;
      v = '{ld: 1'b1, mask: 8'hFF, base: 16'h0A00, stall: 0};
      push_model(v);
      accept(v);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("flush_third_reg", uop_reg, 2);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      q.delete();
      chk("flush_valid", uop_valid, 0);
      chk("flush_ready", start_ready, 1);
      repeat (3) @(posedge clk);
      #1 chk("flush_stays_idle", uop_valid, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Multi-cycle sequencer for IITB-RISC-23 load-multiple (LM) and store-multiple (SM) instructions. It accepts one LM/SM descriptor from decode and expands it into one memory micro-op per set bit of the 8-bit register mask. For LM micro-ops it produces the register-file write-enable and write-address stream that the EX/MEM and MEM/WB pipeline registers carry. The forwarding unit consumes that stream, so this block sits at the producer end of the forwarding interface. It also holds the front end stalled while a sequence is in progress.

## Interface
Parameters:
- `ADDR_W`, 16: memory address width.
- `ADDR_STEP`, 2: address increment per micro-op, in bytes.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start_valid`, in, 1: decode presents an LM/SM descriptor.
- `start_ready`, out, 1: sequencer can accept a descriptor.
- `start_is_load`, in, 1: 1 = LM, 0 = SM.
- `start_mask`, in, 8: bit i set = register Ri is transferred.
- `start_base`, in, ADDR_W: base address, taken from RA.
- `stall_in`, in, 1: downstream pipeline stall; hold the current micro-op.
- `uop_valid`, out, 1: a micro-op is presented.
- `uop_is_load`, out, 1: micro-op type.
- `uop_reg`, out, 3: register index for the micro-op.
- `uop_addr`, out, ADDR_W: memory address for the micro-op.
- `uop_rf_we`, out, 1: equals `uop_valid & uop_is_load`.
- `uop_last`, out, 1: this is the final micro-op of the sequence.
- `frontend_stall`, out, 1: fetch/decode must hold.
- `flush`, in, 1: abort the sequence. This port exists only when `LMSM_ABORT_EN` is defined.

## Operation
- The block has two states, IDLE and RUN. Registered state: `mask_r[7:0]`, `addr_r`, `is_load_r`.
- `start_ready` = (state == IDLE).
- Accept condition: `start_valid & start_ready`.
  - Non-zero mask: load `mask_r`, `addr_r`, and `is_load_r`, then go to RUN.
  - Zero mask: the descriptor is consumed and no micro-ops are emitted. State stays IDLE.
- In RUN:
  - `uop_valid` = 1.
  - `uop_reg` = index of the lowest set bit of `mask_r`, so R0 is transferred first.
  - `uop_addr` = `addr_r`.
  - `uop_last` = 1 when exactly one bit of `mask_r` is set.
- Advance condition is RUN & !`stall_in`. On advance:
  - Clear the lowest set bit of `mask_r`.
  - `addr_r` += `ADDR_STEP`, modulo 2^ADDR_W (silent wrap).
  - If `uop_last` is set, go to IDLE.
- While `stall_in` is high, every `uop_*` output holds stable.
- R0 in the mask is emitted like any other register. Excluding R0 is the consumer's job.
- `frontend_stall` = (state == RUN).
- In IDLE, all `uop_*` outputs are 0.

## Timing
- Reset values:
  - State = IDLE, `mask_r` = 0, `addr_r` = 0, `is_load_r` = 0.
  - `start_ready` = 1.
  - `uop_valid`, `uop_rf_we`, `uop_last`, `frontend_stall`, `uop_reg`, `uop_addr` are all 0.
- Reset asserted mid-sequence drops to IDLE immediately. No further micro-ops are emitted.
- Latency: descriptor accepted at edge T puts the first micro-op on the outputs in cycle T+1.
- Throughput: N set bits with no stalls produce N consecutive micro-op cycles. `start_ready` rises in the cycle after the last micro-op's advance.
- All outputs come from registers or from combinational logic on registers only. There is no input-to-output path other than `start_ready` being state-derived.
- When `start_valid` is asserted during RUN, it is ignored and not stored. Decode must hold it.

## Configuration
- `LMSM_ABORT_EN` defined:
  - The `flush` port exists.
  - `flush` high at an edge while in RUN forces IDLE and clears `mask_r`. No further `uop_valid` follows.
  - `flush` takes priority over `stall_in` and over advance.
  - `flush` in IDLE has no effect.
  - `flush` and accept in the same cycle: accept wins.
- `LMSM_ABORT_EN` undefined: no `flush` port. A sequence always runs to completion unless `rst` is asserted.

## Structure
- Shared `risc23_pkg` holds:
  - `reg_addr_t` (logic [2:0]).
  - `lmsm_state_t` enum (IDLE, RUN).
  - `LMSM_ADDR_STEP` constant.
- One sub-module, `lsb_priority_encoder`, 8-bit input:
  - Outputs: lowest-set index, one-hot of that bit, and an `only_one` flag.
  - The sequencer instantiates it once on `mask_r`.

## Test plan
- Reset: assert `rst` mid-sequence. All outputs go to their reset values asynchronously and `start_ready` = 1.
- LM, mask 8'b1010_0101, base 0x0100, no stall: micro-ops R0@0x0100, R2@0x0102, R5@0x0104, R7@0x0106. `uop_rf_we` = 1 on all four, `uop_last` only on R7, IDLE on the following cycle.
- SM, mask 8'b0000_0011, `stall_in` high for 3 cycles on the first micro-op: R0@base is held for 4 cycles, then R1@base+2. `uop_rf_we` stays 0 throughout.
- Zero mask with `start_valid`: no `uop_valid`, `start_ready` stays 1, `frontend_stall` stays 0.
- Wrap: base 0xFFFE, mask 8'b1100_0000: R6@0xFFFE, then R7@0x0000.
- `LMSM_ABORT_EN`: mask 8'hFF, pulse `flush` during the third micro-op. `uop_valid` = 0 the next cycle and `start_ready` = 1.
